// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin sequencer for a shared 4:1 data mux.
// Four level-held requesters (a..d) compete for one output. The owner keeps
// the grant while it requests. After HOLD_MAX cycles it yields to waiting
// requesters, so no requester can starve the others.
// Optional macro ARB_LOCK_EN adds a 'lock' input. While lock is high, the
// current owner cannot be preempted.
module mux4_rr_arbiter #(
    parameter int DATA_W   = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
`ifdef ARB_LOCK_EN
    input  logic              lock,
`endif
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_out
);

    localparam int              CNT_W   = $clog2(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_gnt;
    logic [1:0]       r_sel;

    state_t           w_nextState;
    logic [1:0]       w_nextPtr;
    logic [CNT_W-1:0] w_nextCnt;
    logic [3:0]       w_nextGnt;
    logic [1:0]       w_nextSel;
    logic [3:0]       w_others;
    logic             w_timeout;
    logic             w_lockHold;

    // Returns the first set bit of vec, searching base+1, base+2, base+3, then base.
    function automatic logic [1:0] rrPick(input logic [1:0] base, input logic [3:0] vec);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = base;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!found && vec[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

`ifdef ARB_LOCK_EN
    assign w_lockHold = lock;
`else
    assign w_lockHold = 1'b0;
`endif

    // This mask holds the requesters other than the current pointer.
    // When the arbiter is in OWN, the pointer is the current owner.
    assign w_others  = req & ~(4'b0001 << r_ptr);
    assign w_timeout = (r_cnt == CNT_MAX);

    // State register: arbiter state, RR pointer, hold counter and the registered grant/select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd3;
            r_cnt   <= '0;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
        end else begin
            r_state <= w_nextState;
            r_ptr   <= w_nextPtr;
            r_cnt   <= w_nextCnt;
            r_gnt   <= w_nextGnt;
            r_sel   <= w_nextSel;
        end
    end

    // Next-state logic. A release takes priority over a timeout, and a new owner is granted without an idle gap.
    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_ptr;
        w_nextCnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    w_nextState = ST_OWN;
                    w_nextPtr   = rrPick(r_ptr, req);
                    w_nextCnt   = '0;
                end
            end
            ST_OWN: begin
                if (!req[r_ptr]) begin
                    w_nextCnt = '0;
                    if (w_others != 4'b0000) begin
                        w_nextPtr = rrPick(r_ptr, w_others);
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end else if (w_timeout && (w_others != 4'b0000) && !w_lockHold) begin
                    w_nextPtr = rrPick(r_ptr, w_others);
                    w_nextCnt = '0;
                end else if (!w_timeout) begin
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_nextState = ST_IDLE;
                w_nextCnt   = '0;
            end
        endcase
    end

    // Grant and select are computed here and then registered.
    // The outputs therefore switch cleanly at the clock edge.
    always_comb begin
        w_nextGnt = 4'b0000;
        w_nextSel = 2'd0;
        if (w_nextState == ST_OWN) begin
            w_nextGnt = 4'b0001 << w_nextPtr;
            w_nextSel = w_nextPtr;
        end
    end

    // Output logic: the valid flag follows the grant, and the mux drives zero when there is no owner.
    always_comb begin
        out_valid = |r_gnt;
        data_out  = '0;
        if (out_valid) begin
            case (r_sel)
                2'd0:    data_out = a;
                2'd1:    data_out = b;
                2'd2:    data_out = c;
                default: data_out = d;
            endcase
        end
    end

    assign gnt = r_gnt;
    assign sel = r_sel;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: self-checking bench for mux4_rr_arbiter (HOLD_MAX=4, DATA_W=8).
// A behavioural model tracks the owner and how many cycles it has held the grant.
// Every cycle, the model predicts gnt, sel, out_valid and data_out.
// Directed scenarios add literal expectations.
// Define ARB_LOCK_EN to build and exercise the lock input.
module tb_mux4_rr_arbiter;

    localparam int DATA_W   = 8;
    localparam int HOLD_MAX = 4;

    logic              clk;
    logic              rst_n;
    logic [3:0]        req;
    logic [DATA_W-1:0] a, b, c, d;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic              out_valid;
    logic [DATA_W-1:0] data_out;
    logic              lockNow;
`ifdef ARB_LOCK_EN
    logic              lock;
`endif

    int total;
    int bad;

    // Model state: owner index (-1 when idle), last owner, and cycles the owner has held the grant.
    int mOwner;
    int mLast;
    int mHeld;
    int mNext;

    mux4_rr_arbiter #(
        .DATA_W   (DATA_W),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .data_out  (data_out)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef ARB_LOCK_EN
    assign lockNow = lock;
`else
    assign lockNow = 1'b0;
`endif

    // Round-robin search. It returns the first set bit of v after 'start', wrapping back to 'start'.
    function automatic int pick(input int start, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            if (v[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    // Decides which requester owns the output after the next edge.
    function automatic int nextOwner(input int owner, input int last, input int held,
                                     input logic [3:0] r, input logic lk);
        logic [3:0] others;
        if (owner < 0) return (r != 4'b0000) ? pick(last, r) : -1;
        others        = r;
        others[owner] = 1'b0;
        if (!r[owner]) return (others != 4'b0000) ? pick(owner, others) : -1;
        if (held >= HOLD_MAX && others != 4'b0000 && !lk) return pick(owner, others);
        return owner;
    endfunction

    // Next owner predicted by the model.
    always_comb mNext = nextOwner(mOwner, mLast, mHeld, req, lockNow);

    // Advances the model once per edge. The model returns to its reset state immediately when rst_n falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mOwner <= -1;
            mLast  <= 3;
            mHeld  <= 0;
        end else begin
            mOwner <= mNext;
            mLast  <= (mNext >= 0) ? mNext : mLast;
            mHeld  <= (mNext < 0) ? 0 : ((mNext == mOwner) ? mHeld + 1 : 1);
        end
    end

    // Performs one counted comparison and reports a mismatch.
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares every DUT output against the model's prediction.
    task automatic checkOutput(input string tag);
        logic [3:0]        eg;
        logic [1:0]        es;
        logic [DATA_W-1:0] ed;
        eg = (mOwner < 0) ? 4'b0000 : (4'b0001 << mOwner);
        es = (mOwner < 0) ? 2'd0 : 2'(mOwner);
        case (mOwner)
            0:       ed = a;
            1:       ed = b;
            2:       ed = c;
            3:       ed = d;
            default: ed = '0;
        endcase
        cmp({tag, ".gnt"}, 32'(gnt), 32'(eg));
        cmp({tag, ".sel"}, 32'(sel), 32'(es));
        cmp({tag, ".valid"}, 32'(out_valid), 32'(mOwner >= 0));
        cmp({tag, ".data"}, 32'(data_out), 32'(ed));
    endtask

    // Waits for the next active edge, then checks the outputs 1 ns later.
    task automatic applyStimulus(input string tag);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        a = '0; b = '0; c = '0; d = '0;
`ifdef ARB_LOCK_EN
        lock = 1'b0;
`endif
        #12;
        cmp("reset.gnt", 32'(gnt), 32'h0);
        cmp("reset.sel", 32'(sel), 32'h0);
        cmp("reset.valid", 32'(out_valid), 32'h0);
        cmp("reset.modelOwner", 32'(mOwner), 32'hffffffff);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic grant followed by a release with no gap cycle.
        req = 4'b0101;
        applyStimulus("basic1");
        cmp("basic1.gntLit", 32'(gnt), 32'h1);
        cmp("basic1.selLit", 32'(sel), 32'h0);
        cmp("basic1.modelOwner", 32'(mOwner), 32'h0);
        req = 4'b0100;
        applyStimulus("basic2");
        cmp("basic2.gntLit", 32'(gnt), 32'h4);
        cmp("basic2.selLit", 32'(sel), 32'h2);

        // Asynchronous reset applied between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        cmp("areset.gnt", 32'(gnt), 32'h0);
        cmp("areset.sel", 32'(sel), 32'h0);
        cmp("areset.valid", 32'(out_valid), 32'h0);
        cmp("areset.data", 32'(data_out), 32'h0);
        req = 4'b1111;
        #2;
        rst_n = 1'b1;

        // Round-robin rotation: each requester receives HOLD_MAX cycles.
        for (int i = 0; i < 20; i++) begin
            applyStimulus("rotate");
            cmp("rotate.gntLit", 32'(gnt), 32'(4'b0001 << ((i / HOLD_MAX) % 4)));
        end

        // A single requester is never preempted.
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            applyStimulus("single");
            cmp("single.gntLit", 32'(gnt), 32'h8);
        end
        req = 4'b0000;
        applyStimulus("singleDrop");
        cmp("singleDrop.gntLit", 32'(gnt), 32'h0);
        cmp("singleDrop.validLit", 32'(out_valid), 32'h0);

        // Data path through the shared mux.
        c   = 8'hA5;
        req = 4'b0100;
        applyStimulus("data");
        cmp("data.selLit", 32'(sel), 32'h2);
        cmp("data.dataLit", 32'(data_out), 32'hA5);
        cmp("data.validLit", 32'(out_valid), 32'h1);
        req = 4'b0000;
        applyStimulus("dataIdle");
        cmp("dataIdle.dataLit", 32'(data_out), 32'h0);

`ifdef ARB_LOCK_EN
        // While lock is high, preemption is blocked. Preemption fires at the edge after lock falls.
        #1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        req  = 4'b0011;
        lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus("lock");
            cmp("lock.gntLit", 32'(gnt), 32'h1);
        end
        lock = 1'b0;
        applyStimulus("unlock");
        cmp("unlock.gntLit", 32'(gnt), 32'h2);
`endif

        // Randomized traffic: sticky requests, random data and occasional mid-cycle resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #3;
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
            a = 8'($urandom);
            b = 8'($urandom);
            c = 8'($urandom);
            d = 8'($urandom);
`ifdef ARB_LOCK_EN
            if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
            applyStimulus("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
